// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jogo_pkg
// Description : Shared definitions for the memory game. Holds the FSM state
//               encoding and the db_estado width, plus a helper that tells
//               whether a state is one of the end-of-game states.
// Revision    : 1.0 - initial release
// ============================================================================
package jogo_pkg;

  localparam int ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h3,
    COMPARA     = 4'h4,
    PROXIMO     = 4'h5,
    NOVA_RODADA = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_ERRO    = 4'hE,
    FIM_TIMEOUT = 4'hF
  } estado_t;

  // True for the three terminal states, where the result flags are held and
  // iniciar is honoured again.
  function automatic logic eh_final(input estado_t e);
    return (e == FIM_ACERTO) || (e == FIM_ERRO) || (e == FIM_TIMEOUT);
  endfunction

endpackage : jogo_pkg
`default_nettype wire

// File: rtl/rom_sequencia.sv
`default_nettype none
// ============================================================================
// Module      : rom_sequencia
// Description : Sequence memory of the game. Word at address a is one-hot
//               with bit (a mod N_CHAVES) set. Purely combinational read.
// Ports       : endereco [W-1:0]        read address
//               dado     [N_CHAVES-1:0] one-hot word at endereco
// Revision    : 1.0 - initial release
// ============================================================================
module rom_sequencia #(
  parameter int N_CHAVES = 4,
  parameter int PROF     = 16,
  localparam int W       = (PROF > 1) ? $clog2(PROF) : 1
) (
  input  logic [W-1:0]        endereco,
  output logic [N_CHAVES-1:0] dado
);

  for (genvar i = 0; i < N_CHAVES; i++) begin : g_onehot
    assign dado[i] = ((int'(endereco) % N_CHAVES) == i);
  end

endmodule : rom_sequencia
`default_nettype wire

// File: rtl/circuito_jogo_param.sv
`default_nettype none
// ============================================================================
// Module      : circuito_jogo_param
// Description : Memory game. Each round r the player must repeat the plays
//               stored at addresses 0..r of the sequence memory. A play is
//               detected when the switches go from all-zero to non-zero. The
//               game ends on a wrong play, on a per-play timeout, or after
//               the last round (PROF-1) is completed.
// Ports       : clock        system clock, rising edge
//               reset        asynchronous reset, active low
//               iniciar      start / restart request (level)
//               chaves       player switches
//               acertou, errou, pronto, timeout   result flags (registered)
//               leds         copy of chaves
//               db_igual     registered play equals memory word
//               db_contagem  play address inside the round
//               db_rodada    current round (0-based)
//               db_memoria   memory word at db_contagem
//               db_jogada    last registered play
//               db_estado    FSM state code
// Revision    : 1.0 - initial release
// ============================================================================
module circuito_jogo_param
  import jogo_pkg::*;
#(
  parameter int N_CHAVES = 4,
  parameter int PROF     = 16,
  parameter int TIMEOUT  = 5000,
  localparam int W       = (PROF > 1) ? $clog2(PROF) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_CHAVES-1:0] chaves,
  output logic                acertou,
  output logic                errou,
  output logic                pronto,
  output logic                timeout,
  output logic [N_CHAVES-1:0] leds,
  output logic                db_igual,
  output logic [W-1:0]        db_contagem,
  output logic [W-1:0]        db_rodada,
  output logic [N_CHAVES-1:0] db_memoria,
  output logic [N_CHAVES-1:0] db_jogada,
  output logic [ESTADO_W-1:0] db_estado
);

  // The timeout counter only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LIMITE_TIMEOUT = TW'(TIMEOUT - 1);
  localparam logic [W-1:0]  ULTIMA_RODADA  = W'(PROF - 1);

  estado_t             estado;
  estado_t             estado_prox;
  logic [W-1:0]        contagem;
  logic [W-1:0]        rodada;
  logic [N_CHAVES-1:0] jogada_reg;
  logic [N_CHAVES-1:0] chaves_ant;
  logic [N_CHAVES-1:0] memoria;
  logic [TW-1:0]       cont_timeout;
  logic                jogada;
  logic                igual;
  logic                fim_tempo;

  rom_sequencia #(
    .N_CHAVES (N_CHAVES),
    .PROF     (PROF)
  ) u_rom (
    .endereco (contagem),
    .dado     (memoria)
  );

  // Rising edge of "any switch on": holding the switches produces one play.
  assign jogada    = (chaves_ant == '0) && (chaves != '0);
  // Whole-word compare, so a multi-hot play never matches a one-hot word.
  assign igual     = (jogada_reg == memoria);
  assign fim_tempo = (cont_timeout == LIMITE_TIMEOUT);

  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL:     if (iniciar) estado_prox = PREPARACAO;
      PREPARACAO:  estado_prox = ESPERA;
      // A play arriving on the last allowed cycle takes precedence.
      ESPERA: begin
        if (jogada)         estado_prox = REGISTRA;
        else if (fim_tempo) estado_prox = FIM_TIMEOUT;
      end
      REGISTRA:    estado_prox = COMPARA;
      COMPARA: begin
        if (!igual)                      estado_prox = FIM_ERRO;
        else if (contagem < rodada)      estado_prox = PROXIMO;
        else if (rodada < ULTIMA_RODADA) estado_prox = NOVA_RODADA;
        else                             estado_prox = FIM_ACERTO;
      end
      PROXIMO:     estado_prox = ESPERA;
      NOVA_RODADA: estado_prox = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) estado_prox = PREPARACAO;
      end
      default:     estado_prox = INICIAL;
    endcase
  end

  // State, datapath registers and result flags. Flags are derived from the
  // next state so they appear in the same cycle as the terminal state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= INICIAL;
      contagem     <= '0;
      rodada       <= '0;
      jogada_reg   <= '0;
      chaves_ant   <= '0;
      cont_timeout <= '0;
      acertou      <= 1'b0;
      errou        <= 1'b0;
      pronto       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      estado     <= estado_prox;
      chaves_ant <= chaves;
      acertou    <= (estado_prox == FIM_ACERTO);
      errou      <= (estado_prox == FIM_ERRO) || (estado_prox == FIM_TIMEOUT);
      timeout    <= (estado_prox == FIM_TIMEOUT);
      pronto     <= eh_final(estado_prox);

      case (estado)
        PREPARACAO: begin
          contagem     <= '0;
          rodada       <= '0;
          jogada_reg   <= '0;
          cont_timeout <= '0;
        end
        ESPERA: begin
          if (!jogada && !fim_tempo) cont_timeout <= cont_timeout + TW'(1);
        end
        REGISTRA: jogada_reg <= chaves;
        PROXIMO: begin
          contagem     <= contagem + W'(1);
          cont_timeout <= '0;
        end
        NOVA_RODADA: begin
          rodada       <= rodada + W'(1);
          contagem     <= '0;
          cont_timeout <= '0;
        end
        default: ;
      endcase
    end
  end

  assign leds        = chaves;
  assign db_igual    = igual;
  assign db_contagem = contagem;
  assign db_rodada   = rodada;
  assign db_memoria  = memoria;
  assign db_jogada   = jogada_reg;
  assign db_estado   = estado;

endmodule : circuito_jogo_param
`default_nettype wire

// File: tb/tb_circuito_jogo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_circuito_jogo_param
// Description : Directed self-checking bench for circuito_jogo_param with
//               N_CHAVES=4, PROF=4, TIMEOUT=20.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_circuito_jogo_param;

  localparam int N_CHAVES = 4;
  localparam int PROF     = 4;
  localparam int TIMEOUT  = 20;
  localparam int W        = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                iniciar;
  logic [N_CHAVES-1:0] chaves;
  logic                acertou, errou, pronto, timeout;
  logic [N_CHAVES-1:0] leds;
  logic                db_igual;
  logic [W-1:0]        db_contagem, db_rodada;
  logic [N_CHAVES-1:0] db_memoria, db_jogada;
  logic [3:0]          db_estado;

  int checks = 0;
  int errors = 0;

  circuito_jogo_param #(
    .N_CHAVES (N_CHAVES),
    .PROF     (PROF),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .chaves      (chaves),
    .acertou     (acertou),
    .errou       (errou),
    .pronto      (pronto),
    .timeout     (timeout),
    .leds        (leds),
    .db_igual    (db_igual),
    .db_contagem (db_contagem),
    .db_rodada   (db_rodada),
    .db_memoria  (db_memoria),
    .db_jogada   (db_jogada),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // flags packed as {acertou, errou, timeout, pronto}
  task automatic chk_flags(input string tag, input logic [3:0] expv);
    chk(tag, {28'd0, acertou, errou, timeout, pronto}, {28'd0, expv});
  endtask

  // One play from espera: hold switches through registra, release in compara.
  task automatic jogar(input logic [3:0] v, input logic exp_igual, input logic [3:0] exp_estado);
    chaves = v;
    tick();
    chk("registra", {28'd0, db_estado}, 32'h3);
    chk("leds", {28'd0, leds}, {28'd0, v});
    tick();
    chk("compara", {28'd0, db_estado}, 32'h4);
    chk("db_jogada", {28'd0, db_jogada}, {28'd0, v});
    chk("db_igual", {31'd0, db_igual}, {31'd0, exp_igual});
    chaves = '0;
    tick();
    chk("resultado", {28'd0, db_estado}, {28'd0, exp_estado});
  endtask

  initial begin
    logic [3:0] est;
    reset   = 1'b0;
    iniciar = 1'b0;
    chaves  = '0;

    // Reset state
    #3;
    chk("rst_estado", {28'd0, db_estado}, 32'h0);
    chk_flags("rst_flags", 4'b0000);
    #9 reset = 1'b1;
    tick();
    chk("inicial_hold", {28'd0, db_estado}, 32'h0);

    // Full correct game
    iniciar = 1'b1;
    tick();
    chk("preparacao", {28'd0, db_estado}, 32'h1);
    iniciar = 1'b0;
    tick();
    chk("espera", {28'd0, db_estado}, 32'h2);
    for (int r = 0; r < PROF; r++) begin
      for (int c = 0; c <= r; c++) begin
        est = (c < r) ? 4'h5 : ((r < PROF - 1) ? 4'h6 : 4'hA);
        jogar(4'(1 << c), 1'b1, est);
        if (est != 4'hA) tick();
      end
    end
    chk_flags("acerto_flags", 4'b1001);
    chk("acerto_rodada", {30'd0, db_rodada}, 32'd3);
    chk("acerto_contagem", {30'd0, db_contagem}, 32'd3);
    tick();
    chk("acerto_hold", {28'd0, db_estado}, 32'hA);

    // Wrong second play in round 1
    iniciar = 1'b1;
    tick();
    chk("restart_a", {28'd0, db_estado}, 32'h1);
    chk_flags("restart_a_flags", 4'b0000);
    iniciar = 1'b0;
    tick();
    jogar(4'b0001, 1'b1, 4'h6);
    tick();
    jogar(4'b0001, 1'b1, 4'h5);
    tick();
    jogar(4'b0100, 1'b0, 4'hE);
    chk_flags("erro_flags", 4'b0101);
    chk("erro_jogada", {28'd0, db_jogada}, 32'h4);

    // Restart from fim_erro, iniciar ignored in espera, then timeout
    iniciar = 1'b1;
    tick();
    chk("restart_e", {28'd0, db_estado}, 32'h1);
    chk_flags("restart_e_flags", 4'b0000);
    tick();
    chk("iniciar_espera_1", {28'd0, db_estado}, 32'h2);
    tick();
    chk("iniciar_espera_2", {28'd0, db_estado}, 32'h2);
    iniciar = 1'b0;
    repeat (8) tick();
    chk("espera_antes_timeout", {28'd0, db_estado}, 32'h2);
    chk_flags("espera_flags", 4'b0000);
    repeat (15) tick();
    chk("timeout_estado", {28'd0, db_estado}, 32'hF);
    chk_flags("timeout_flags", 4'b0111);

    // Held switches give exactly one play; multi-hot play mismatches
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    chaves = 4'b0001;
    tick();
    chk("hold_registra", {28'd0, db_estado}, 32'h3);
    tick();
    tick();
    chk("hold_nova", {28'd0, db_estado}, 32'h6);
    tick();
    tick();
    tick();
    chk("hold_sem_jogada", {28'd0, db_estado}, 32'h2);
    chk("hold_rodada", {30'd0, db_rodada}, 32'd1);
    chaves = '0;
    tick();
    chk("hold_solto", {28'd0, db_estado}, 32'h2);
    jogar(4'b0011, 1'b0, 4'hE);
    chk_flags("multihot_flags", 4'b0101);

    // Asynchronous reset mid-espera in round 2
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    jogar(4'b0001, 1'b1, 4'h6);
    tick();
    jogar(4'b0001, 1'b1, 4'h5);
    tick();
    jogar(4'b0010, 1'b1, 4'h6);
    tick();
    chk("pre_rst_estado", {28'd0, db_estado}, 32'h2);
    chk("pre_rst_rodada", {30'd0, db_rodada}, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_estado", {28'd0, db_estado}, 32'h0);
    chk("async_rst_rodada", {30'd0, db_rodada}, 32'd0);
    chk("async_rst_jogada", {28'd0, db_jogada}, 32'h0);
    chk_flags("async_rst_flags", 4'b0000);
    repeat (2) tick();
    iniciar = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("release_no_edge", {28'd0, db_estado}, 32'h0);
    tick();
    chk("release_edge", {28'd0, db_estado}, 32'h1);
    iniciar = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_circuito_jogo_param
`default_nettype wire

// File: doc/circuito_jogo_param.md
CIRCUITO_JOGO_PARAM -- requirements
Module: circuito_jogo_param

Interface
REQ-001 Parameter N_CHAVES, default 4: number of switches/LEDs; width of each stored play.
REQ-002 Parameter PROF, default 16: maximum sequence depth (rounds); power of two, >=2; W=$clog2(PROF).
REQ-003 Parameter TIMEOUT, default 5000: clock cycles allowed per play in state espera.
REQ-004 clock  in  1  single system clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 iniciar  in  1  start/restart request, level-sampled.
REQ-007 chaves  in  N_CHAVES  player switches, synchronous to clock.
REQ-008 acertou, errou, pronto, timeout  out  1 each  game-result flags.
REQ-009 leds  out  N_CHAVES  equals chaves combinationally.
REQ-010 db_igual  out  1  registered play equals memory word.
REQ-011 db_contagem, db_rodada  out  W each  play address; current round index (0-based).
REQ-012 db_memoria, db_jogada  out  N_CHAVES each  memory word at db_contagem; last registered play.
REQ-013 db_estado  out  4  encoded FSM state.

Function
REQ-014 Memory word at address a SHALL be one-hot: bit (a mod N_CHAVES) set.
REQ-015 jogada SHALL pulse one cycle when chaves goes from all-zero (previous cycle) to non-zero.
REQ-016 States/codes: inicial=0, preparacao=1, espera=2, registra=3, compara=4, proximo=5, nova_rodada=6, fim_acerto=A, fim_erro=E, fim_timeout=F.
REQ-017 inicial: all flags 0; iniciar=1 -> preparacao.
REQ-018 preparacao: contagem=0, rodada=0, jogada register=0, timeout counter=0; -> espera.
REQ-019 espera: timeout counter increments each cycle; jogada -> registra; counter reaching TIMEOUT-1 without jogada -> fim_timeout; jogada on that same cycle wins.
REQ-020 registra: load chaves into jogada register; -> compara.
REQ-021 compara: not igual -> fim_erro; igual and contagem<rodada -> proximo; igual, contagem==rodada, rodada<PROF-1 -> nova_rodada; igual, contagem==rodada==PROF-1 -> fim_acerto.
REQ-022 proximo: contagem+1, timeout counter cleared; -> espera.
REQ-023 nova_rodada: rodada+1, contagem=0, timeout counter cleared; -> espera.
REQ-024 Multi-hot plays SHALL compare as whole words (therefore mismatch).
REQ-025 fim_acerto: acertou=1, pronto=1; fim_erro: errou=1, pronto=1; fim_timeout: errou=1, timeout=1, pronto=1; flags hold until iniciar=1 -> preparacao.
REQ-026 iniciar SHALL be ignored in all states except inicial and fim_*.
REQ-027 Counters SHALL never wrap: contagem<=rodada<=PROF-1 always.
REQ-028 Latency: jogada pulse to compara result = 2 cycles; result flag visible the cycle after compara.

Reset
REQ-029 reset=0 SHALL immediately force inicial, all counters/registers to 0, all flags 0, from any state including mid-round.
REQ-030 After reset release, first state change SHALL require a rising clock edge.

Structure
REQ-031 State codes and db_estado width SHALL live in shared package jogo_pkg.
REQ-032 Sequence memory SHALL be sub-module rom_sequencia (parameters N_CHAVES, PROF; combinational read).
REQ-033 FSM and datapath MAY be split into uc/fluxo halves; top-level ports unchanged.

Verification (N_CHAVES=4, PROF=4, TIMEOUT=20)
REQ-034 Reset mid-espera, round 2 -> db_estado=0, db_rodada=0, all flags 0 asynchronously.
REQ-035 Full correct game: plays 0001; 0001,0010; 0001,0010,0100; 0001,0010,0100,1000 -> acertou=1, pronto=1, db_estado=A.
REQ-036 Round 1, second play 0100 instead of 0010 -> errou=1, timeout=0, db_estado=E, db_jogada=0100.
REQ-037 No play 20 cycles after preparacao -> errou=1, timeout=1, db_estado=F.
REQ-038 Play 0011 at address 0 -> errou=1; chaves held non-zero across cycles -> exactly one jogada.
REQ-039 iniciar=1 during espera -> no state change; iniciar=1 in fim_erro -> preparacao, flags cleared next cycle.
